regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters:
  - A: ALU/execute result.
  - B: load / multiply-divide result.
- Each requester gets a one-entry holding register with a valid/ready handshake.
- Grants one write per cycle, preserves write order to the same register, and drives registered we/index/data to the register file.
- Exports a pending-write mask so the hazard logic can stall readers of registers whose writes are still queued.

Parameters:
- DATA_W, 32, write data width.
- IDX_W, 5, register index width; register count = 2**IDX_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A holding slot can accept.
- a_index  in  IDX_W  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B holding slot can accept.
- b_index  in  IDX_W  B destination register.
- b_data  in  DATA_W  B write data.
- rf_we  out  1  register file write enable (registered).
- rf_windex  out  IDX_W  register file write index (registered).
- rf_win  out  DATA_W  register file write data (registered).
- pend_mask  out  2**IDX_W  bit i set = write to register i queued or in output stage.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset state:
  - Both holding slots empty.
  - rf_we=0, rf_windex=0, rf_win=0, pend_mask=0.
  - Age bit = A-older; round-robin pointer = A.
  - a_ready/b_ready forced 0 while rst_n low; 1 in the first cycle after release.
- Handshake:
  - A transfer occurs on a rising edge with x_valid && x_ready.
  - x_ready = !x_full || x_grant.
  - x_grant is a function of registered state only; there is no valid-to-ready combinational path.
  - Each requester sustains 1 transfer per cycle; data/index are sampled on transfer.
- Register 0:
  - Transfers with index 0 are accepted (ready obeyed) and discarded.
  - They never occupy a slot, never set pend_mask, never assert rf_we.
- Age tracking:
  - A 1-bit age flag records which occupied slot was filled first.
  - Simultaneous fills of both empty slots: A counts as older.
  - A slot refilled while the other slot remains occupied is younger.
- Arbitration, each cycle, over occupied slots:
  - One slot occupied: grant it.
  - Both occupied, same index: grant the older slot (same-register order preserved).
  - Both occupied, different index: round-robin. Grant the slot not granted last; the pointer updates only on a two-way grant.
- Output stage:
  - The granted slot empties on the edge.
  - The same edge sets rf_we=1, rf_windex/rf_win = slot contents.
  - No grant: rf_we=0; rf_windex/rf_win hold previous values.
- Latency: transfer at edge N, slot valid after N, write presented after edge N+1, register file writes at edge N+2. Minimum 2 cycles, transfer to rf_we.
- pend_mask:
  - Combinational OR of one-hot(index) over occupied slots and the output stage when rf_we=1.
  - Clears the cycle after the register file write edge.
- Throughput: 1 write per cycle total; a requester with an occupied, ungranted slot sees ready=0.
- Reset mid-operation: queued and in-flight writes are dropped; outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: RF_WB_ARB_FIXED_PRIO_EN.
- Defined:
  - Round-robin pointer removed.
  - With both occupied and different indices, A is always granted.
  - The same-index rule still grants the older slot.
- Undefined: round-robin as above.

Test Plan:
- Reset then A writes idx 3 = 0xDEADBEEF → a_ready=1; rf_we=1, rf_windex=3, rf_win=0xDEADBEEF exactly 2 cycles after transfer; pend_mask bit 3 high for those 2 cycles then 0.
- B transfer idx 0 data 0x1234 → accepted; rf_we stays 0; pend_mask stays 0.
- A and B transfer same cycle, idx 5 = 0x11 (A) and idx 5 = 0x22 (B) → writes issued A then B on consecutive cycles; final rf_win=0x22.
- A and B both valid every cycle, distinct indices 1/2 → rf_we continuously 1, alternating grants. With RF_WB_ARB_FIXED_PRIO_EN defined, A writes back-to-back and b_ready stays 0 until A idles.
- B fills slot idx 7 while A slot holds idx 7 from earlier → A granted first despite round-robin pointer favouring A-last; B granted next cycle.
- Assert rst_n low while both slots full and rf_we=1 → rf_we, pend_mask, ready drop to 0 immediately; no write issued after rst_n release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between two writeback
// requesters: A (ALU/execute) and B (load / multiply-divide). Each requester
// has a one-entry holding slot with a valid/ready handshake. One slot is
// granted per cycle. Writes to the same register leave in arrival order.
// The write is presented to the register file through a registered output
// stage. pend_mask marks every register whose write is still queued or in
// the output stage.
//
// Optional feature: define RF_WB_ARB_FIXED_PRIO_EN to replace the round-robin
// choice between two different registers with fixed priority for A. The
// same-register rule (older slot first) is kept in both builds.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [IDX_W-1:0]      a_index,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [IDX_W-1:0]      b_index,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  rf_we,
  output logic [IDX_W-1:0]      rf_windex,
  output logic [DATA_W-1:0]     rf_win,
  output logic [(2**IDX_W)-1:0] pend_mask
);

  localparam int NREG = 2 ** IDX_W;

  // Holding slots
  logic              a_full_reg;
  logic [IDX_W-1:0]  a_index_reg;
  logic [DATA_W-1:0] a_data_reg;
  logic              b_full_reg;
  logic [IDX_W-1:0]  b_index_reg;
  logic [DATA_W-1:0] b_data_reg;

  // age_reg: 0 = A slot filled first (or equal), 1 = B slot filled first
  logic age_reg;
  logic age_next;

`ifndef RF_WB_ARB_FIXED_PRIO_EN
  // rr_reg: requester favoured on the next contested grant (0 = A, 1 = B)
  logic rr_reg;
  logic rr_next;
`endif

  logic a_grant;
  logic b_grant;
  logic a_fill;
  logic b_fill;
  logic a_stays;
  logic b_stays;

  // Grant selection: depends on registered slot state only
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (a_full_reg && b_full_reg) begin
      if (a_index_reg == b_index_reg) begin
        // Same destination: the older write must land first
        a_grant = !age_reg;
        b_grant = age_reg;
      end else begin
`ifdef RF_WB_ARB_FIXED_PRIO_EN
        a_grant = 1'b1;
`else
        a_grant = !rr_reg;
        b_grant = rr_reg;
`endif
      end
    end else begin
      a_grant = a_full_reg;
      b_grant = b_full_reg;
    end
  end

  // Handshake: a slot accepts when empty or emptying this edge; ready is held
  // low while reset is asserted. Index 0 transfers are accepted but dropped.
  always_comb begin
    a_ready = rst_n && (!a_full_reg || a_grant);
    b_ready = rst_n && (!b_full_reg || b_grant);
    a_fill  = a_valid && a_ready && (a_index != '0);
    b_fill  = b_valid && b_ready && (b_index != '0);
    a_stays = a_full_reg && !a_grant;
    b_stays = b_full_reg && !b_grant;
  end

  // Age flag next state: a slot that refills while the other slot stays
  // occupied becomes the younger one; simultaneous fills make A older
  always_comb begin
    age_next = age_reg;
    if (a_stays && b_stays) begin
      age_next = age_reg;
    end else if (b_stays && a_fill) begin
      age_next = 1'b1;
    end else begin
      age_next = 1'b0;
    end
  end

`ifndef RF_WB_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves only when both slots competed for the grant
  always_comb begin
    rr_next = rr_reg;
    if (a_full_reg && b_full_reg) begin
      rr_next = a_grant;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_reg <= 1'b0;
    end else begin
      rr_reg <= rr_next;
    end
  end
`endif

  // Age flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_reg <= 1'b0;
    end else begin
      age_reg <= age_next;
    end
  end

  // Slot A: load on accepted non-zero transfer, empty on grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full_reg  <= 1'b0;
      a_index_reg <= '0;
      a_data_reg  <= '0;
    end else if (a_fill) begin
      a_full_reg  <= 1'b1;
      a_index_reg <= a_index;
      a_data_reg  <= a_data;
    end else if (a_grant) begin
      a_full_reg  <= 1'b0;
    end
  end

  // Slot B: load on accepted non-zero transfer, empty on grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_full_reg  <= 1'b0;
      b_index_reg <= '0;
      b_data_reg  <= '0;
    end else if (b_fill) begin
      b_full_reg  <= 1'b1;
      b_index_reg <= b_index;
      b_data_reg  <= b_data;
    end else if (b_grant) begin
      b_full_reg  <= 1'b0;
    end
  end

  // Output stage: present the granted slot; index/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we     <= 1'b0;
      rf_windex <= '0;
      rf_win    <= '0;
    end else if (a_grant) begin
      rf_we     <= 1'b1;
      rf_windex <= a_index_reg;
      rf_win    <= a_data_reg;
    end else if (b_grant) begin
      rf_we     <= 1'b1;
      rf_windex <= b_index_reg;
      rf_win    <= b_data_reg;
    end else begin
      rf_we     <= 1'b0;
    end
  end

  // Pending mask: one bit per register, set while a write to it is in a slot
  // or in the output stage
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
      assign pend_mask[gi] = (a_full_reg && (a_index_reg == IDX_W'(gi))) ||
                             (b_full_reg && (b_index_reg == IDX_W'(gi))) ||
                             (rf_we      && (rf_windex   == IDX_W'(gi)));
    end
  endgenerate

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Directed test of the writeback arbiter. Expected values are hand-computed
// per scenario. Honours RF_WB_ARB_FIXED_PRIO_EN when it is defined.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;

  logic              clk;
  logic              rst_n;
  logic              a_valid;
  logic              a_ready;
  logic [IDX_W-1:0]  a_index;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [IDX_W-1:0]  b_index;
  logic [DATA_W-1:0] b_data;
  logic              rf_we;
  logic [IDX_W-1:0]  rf_windex;
  logic [DATA_W-1:0] rf_win;
  logic [31:0]       pend_mask;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_index   (a_index),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_index   (b_index),
    .b_data    (b_data),
    .rf_we     (rf_we),
    .rf_windex (rf_windex),
    .rf_win    (rf_win),
    .pend_mask (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per register-file write
  always @(negedge clk) begin
    if (rst_n && rf_we) $display("rf write idx=%0d data=%08h", rf_windex, rf_win);
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  logic [IDX_W-1:0]  prev_idx;
  logic [IDX_W-1:0]  exp_idx [3];
  logic [DATA_W-1:0] exp_dat [3];
  logic              sent;
  logic              drained;

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b0; a_index = '0; a_data = '0;
    b_valid = 1'b0; b_index = '0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_we",      rf_we,     0);
    check("rst_windex",  rf_windex, 0);
    check("rst_win",     rf_win,    0);
    check("rst_pend",    pend_mask, 0);
    check("rst_a_ready", a_ready,   0);
    check("rst_b_ready", b_ready,   0);
    rst_n = 1'b1;
    #1;
    check("rel_a_ready", a_ready, 1);
    check("rel_b_ready", b_ready, 1);

    // Single A write, idx 3
    a_valid = 1'b1; a_index = 5'd3; a_data = 32'hDEADBEEF;
    check("t1_a_ready", a_ready, 1);
    cyc;
    a_valid = 1'b0;
    check("t1_we_n1",   rf_we,     0);
    check("t1_pend_n1", pend_mask, 32'h8);
    cyc;
    check("t1_we_n2",   rf_we,     1);
    check("t1_idx_n2",  rf_windex, 3);
    check("t1_win_n2",  rf_win,    32'hDEADBEEF);
    check("t1_pend_n2", pend_mask, 32'h8);
    cyc;
    check("t1_we_n3",   rf_we,     0);
    check("t1_pend_n3", pend_mask, 0);

    // B write to register 0 is swallowed
    b_valid = 1'b1; b_index = 5'd0; b_data = 32'h1234;
    check("t2_b_ready", b_ready, 1);
    cyc;
    b_valid = 1'b0;
    check("t2_we_1",   rf_we,     0);
    check("t2_pend_1", pend_mask, 0);
    cyc;
    check("t2_we_2",   rf_we,     0);
    check("t2_pend_2", pend_mask, 0);
    check("t2_win_hold", rf_win, 32'hDEADBEEF);

    // Same register from both sides in one cycle: A first, then B
    a_valid = 1'b1; a_index = 5'd5; a_data = 32'h11;
    b_valid = 1'b1; b_index = 5'd5; b_data = 32'h22;
    cyc;
    a_valid = 1'b0; b_valid = 1'b0;
    check("t3_pend_fill", pend_mask, 32'h20);
    check("t3_we_fill",   rf_we,     0);
    cyc;
    check("t3_we_1",  rf_we,     1);
    check("t3_idx_1", rf_windex, 5);
    check("t3_win_1", rf_win,    32'h11);
    cyc;
    check("t3_we_2",   rf_we,     1);
    check("t3_win_2",  rf_win,    32'h22);
    check("t3_pend_2", pend_mask, 32'h20);
    cyc;
    check("t3_we_3",   rf_we,     0);
    check("t3_pend_3", pend_mask, 0);

    // Continuous contention on distinct registers 1 and 2
    a_valid = 1'b1; a_index = 5'd1; a_data = 32'hA1A1A1A1;
    b_valid = 1'b1; b_index = 5'd2; b_data = 32'hB2B2B2B2;
    cyc;
    check("t4_pend_fill", pend_mask, 32'h6);
    prev_idx = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef RF_WB_ARB_FIXED_PRIO_EN
      check("t4_b_ready_blocked", b_ready, 0);
`else
      check("t4_one_ready", 32'(a_ready) + 32'(b_ready), 1);
`endif
      cyc;
      check("t4_we_stream", rf_we, 1);
`ifdef RF_WB_ARB_FIXED_PRIO_EN
      check("t4_idx_a_only", rf_windex, 1);
`else
      if (i > 0) check("t4_alternate", (rf_windex != prev_idx), 1);
      check("t4_idx_legal", (rf_windex == 5'd1) || (rf_windex == 5'd2), 1);
`endif
      prev_idx = rf_windex;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    drained = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc;
      if (!rf_we && pend_mask == 0) begin
        drained = 1'b1;
        break;
      end
    end
    check("t4_drained", drained, 1);

    // Same register queued behind a contested grant; fresh reset so the
    // round-robin state is known
    rst_n = 1'b0;
    #1;
    cyc;
    rst_n = 1'b1;
    a_valid = 1'b1; a_index = 5'd9;  a_data = 32'h9A;
    b_valid = 1'b1; b_index = 5'd10; b_data = 32'h10B;
    cyc;
    a_valid = 1'b0; b_valid = 1'b0;
    cyc;
    check("t5_pre_idx1", rf_windex, 9);
    cyc;
    check("t5_pre_idx2", rf_windex, 10);
    cyc;
    check("t5_pre_idle", rf_we, 0);

    a_valid = 1'b1; a_index = 5'd7; a_data = 32'h77A;
    b_valid = 1'b1; b_index = 5'd9; b_data = 32'h99B;
    cyc;
    a_valid = 1'b0;
    b_index = 5'd7; b_data = 32'h77B;
    check("t5_pend_fill", pend_mask, 32'h280);
`ifdef RF_WB_ARB_FIXED_PRIO_EN
    check("t5_b_ready", b_ready, 0);
    exp_idx[0] = 5'd7; exp_dat[0] = 32'h77A;
    exp_idx[1] = 5'd9; exp_dat[1] = 32'h99B;
    exp_idx[2] = 5'd7; exp_dat[2] = 32'h77B;
`else
    check("t5_b_ready", b_ready, 1);
    exp_idx[0] = 5'd9; exp_dat[0] = 32'h99B;
    exp_idx[1] = 5'd7; exp_dat[1] = 32'h77A;
    exp_idx[2] = 5'd7; exp_dat[2] = 32'h77B;
`endif
    for (int k = 0; k < 3; k++) begin
      sent = b_valid && b_ready;
      cyc;
      if (sent) b_valid = 1'b0;
      check("t5_we",  rf_we,     1);
      check("t5_idx", rf_windex, exp_idx[k]);
      check("t5_win", rf_win,    exp_dat[k]);
    end
    b_valid = 1'b0;
    cyc;
    check("t5_idle_we",   rf_we,     0);
    check("t5_idle_pend", pend_mask, 0);

    // Asynchronous reset with both slots full and a write in flight
    a_valid = 1'b1; a_index = 5'd1; a_data = 32'h1111;
    b_valid = 1'b1; b_index = 5'd2; b_data = 32'h2222;
    cyc;
    cyc;
    check("t6_pre_we", rf_we, 1);
    rst_n = 1'b0;
    #1;
    check("t6_we",      rf_we,     0);
    check("t6_pend",    pend_mask, 0);
    check("t6_a_ready", a_ready,   0);
    check("t6_b_ready", b_ready,   0);
    check("t6_windex",  rf_windex, 0);
    check("t6_win",     rf_win,    0);
    a_valid = 1'b0; b_valid = 1'b0;
    cyc;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc;
      check("t6_post_we",   rf_we,     0);
      check("t6_post_pend", pend_mask, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
